// File: rtl/icache_miss_ctrl_pkg.sv
// Shared widths and FSM encoding for the I-cache refill sequencer.
package icache_miss_ctrl_pkg;

  localparam int ADDR_WIDTH        = 32;
  localparam int ICACHE_BLOCK_SIZE = 64;
  localparam int OFFSET_BITS       = $clog2(ICACHE_BLOCK_SIZE / 8);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FILL  = 3'd3,
    ST_DRAIN = 3'd4
  } miss_state_e;

endpackage

// File: rtl/icache_miss_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module icache_miss_ctrl_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/icache_miss_ctrl.sv
// I-cache miss sequencer: stalls fetch, fetches one block from DRAM, writes it
// into the cache, and tolerates branch-recovery flushes at any point.
module icache_miss_ctrl
  import icache_miss_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH        = icache_miss_ctrl_pkg::ADDR_WIDTH,
  parameter int ICACHE_BLOCK_SIZE = icache_miss_ctrl_pkg::ICACHE_BLOCK_SIZE,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         rst_aH,
  input  logic                         lookup_valid,
  input  logic [ADDR_WIDTH-1:0]        lookup_addr,
  input  logic                         cache_hit,
  input  logic                         recovery_PC_valid,
  output logic                         miss_stall,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_WIDTH-1:0]        mem_req_addr,
  input  logic                         mem_resp_valid,
  input  logic [ICACHE_BLOCK_SIZE-1:0] mem_resp_data,
  output logic                         refill_we,
  output logic [ADDR_WIDTH-1:0]        refill_addr,
  output logic [ICACHE_BLOCK_SIZE-1:0] refill_data,
  output logic [CNT_WIDTH-1:0]         miss_count
);

  localparam int                    BLK_OFFSET_BITS = $clog2(ICACHE_BLOCK_SIZE / 8);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK     = ADDR_WIDTH'((1 << BLK_OFFSET_BITS) - 1);

  miss_state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [ICACHE_BLOCK_SIZE-1:0] data_q, data_d;
  logic                         req_valid_q, req_valid_d;
  logic                         refill_we_q, refill_we_d;

  logic                  miss_now;
  logic                  req_accept;
  logic [ADDR_WIDTH-1:0] blk_addr;

  // A miss that coincides with a redirect is wrong-path and never starts a refill.
  assign miss_now   = (state_q == ST_IDLE) && lookup_valid && !cache_hit && !recovery_PC_valid;
  assign req_accept = (state_q == ST_REQ) && mem_req_ready;
  assign blk_addr   = lookup_addr & ~OFFSET_MASK;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (miss_now) begin
          state_d = ST_REQ;
          addr_d  = blk_addr;
        end
      end
      ST_REQ: begin
        // Once accepted, a response is owed even if the fetch was flushed.
        if (mem_req_ready) begin
          state_d = recovery_PC_valid ? ST_DRAIN : ST_WAIT;
        end else if (recovery_PC_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid && recovery_PC_valid) begin
          state_d = ST_IDLE;
        end else if (mem_resp_valid) begin
          state_d = ST_FILL;
          data_d  = mem_resp_data;
        end else if (recovery_PC_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_FILL: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (mem_resp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_valid_d = (state_d == ST_REQ);
    refill_we_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      req_valid_q <= 1'b0;
      refill_we_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      req_valid_q <= req_valid_d;
      refill_we_q <= refill_we_d;
    end
  end

  icache_miss_ctrl_sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_miss_cnt (
    .clk  (clk),
    .rst  (rst_aH),
    .inc  (req_accept),
    .count(miss_count)
  );

  assign miss_stall    = (state_q != ST_IDLE) || miss_now;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = addr_q;
  assign refill_we     = refill_we_q;
  assign refill_addr   = addr_q;
  assign refill_data   = data_q;

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Directed cycle-by-cycle vectors plus reset and counter-saturation sequences.
module tb_icache_miss_ctrl;

  logic        clk;
  logic        rst_aH;
  logic        lookup_valid;
  logic [31:0] lookup_addr;
  logic        cache_hit;
  logic        recovery_PC_valid;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  logic        miss_stall, mem_req_valid, refill_we;
  logic [31:0] mem_req_addr, refill_addr;
  logic [63:0] refill_data;
  logic [15:0] miss_count;

  logic        s_miss_stall, s_mem_req_valid, s_refill_we;
  logic [31:0] s_mem_req_addr, s_refill_addr;
  logic [63:0] s_refill_data;
  logic [3:0]  s_miss_count;

  icache_miss_ctrl dut (
    .clk(clk), .rst_aH(rst_aH), .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
    .cache_hit(cache_hit), .recovery_PC_valid(recovery_PC_valid), .miss_stall(miss_stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .refill_we(refill_we),
    .refill_addr(refill_addr), .refill_data(refill_data), .miss_count(miss_count)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  icache_miss_ctrl #(.CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst_aH(rst_aH), .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
    .cache_hit(cache_hit), .recovery_PC_valid(recovery_PC_valid), .miss_stall(s_miss_stall),
    .mem_req_valid(s_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(s_mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .refill_we(s_refill_we),
    .refill_addr(s_refill_addr), .refill_data(s_refill_data), .miss_count(s_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [31:0] addr;
    logic        hit;
    logic        rec;
    logic        rdy;
    logic        rsp;
    logic [63:0] data;
    logic        e_stall;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_we;
    logic [63:0] e_wdata;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   vidx  = 0;

  localparam logic [63:0] Z  = 64'h0;
  localparam logic [63:0] DA = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] DB = 64'h01234567_89ABCDEF;
  localparam logic [63:0] DC = 64'h00000000_000055AA;

  function automatic void add(input int lv, input logic [31:0] a, input int hit, input int rec,
                              input int rdy, input int rsp, input logic [63:0] d,
                              input int es, input int erv, input logic [31:0] ea,
                              input int ewe, input logic [63:0] ewd, input int ec);
    vec_t v;
    v.lv = (lv != 0); v.addr = a; v.hit = (hit != 0); v.rec = (rec != 0);
    v.rdy = (rdy != 0); v.rsp = (rsp != 0); v.data = d;
    v.e_stall = (es != 0); v.e_rv = (erv != 0); v.e_addr = ea;
    v.e_we = (ewe != 0); v.e_wdata = ewd; v.e_cnt = 16'(ec);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%h required=%h", nm, vidx, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [31:0] a, input logic hit, input logic rec,
                       input logic rdy, input logic rsp, input logic [63:0] d);
    lookup_valid = lv; lookup_addr = a; cache_hit = hit; recovery_PC_valid = rec;
    mem_req_ready = rdy; mem_resp_valid = rsp; mem_resp_data = d;
  endtask

  task automatic do_miss(input logic [31:0] a);
    @(negedge clk); drive(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0, Z);
    @(negedge clk); drive(1'b1, a, 1'b0, 1'b0, 1'b1, 1'b0, Z);
    @(negedge clk); drive(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b1, DA);
    @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, Z);
  endtask

  initial begin
    rst_aH = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, Z);

    // Basic miss: 0x1004 -> block 0x1000, response five cycles after the miss
    add(1,32'h1004,0,0,0,0,Z,  1,0,0,0,Z,0);
    add(1,32'h1004,0,0,1,0,Z,  1,1,32'h1000,0,Z,0);
    add(1,32'h1004,0,0,0,0,Z,  1,0,0,0,Z,1);
    add(1,32'h1004,0,0,0,0,Z,  1,0,0,0,Z,1);
    add(1,32'h1004,0,0,0,0,Z,  1,0,0,0,Z,1);
    add(1,32'h1004,0,0,0,0,Z,  1,0,0,0,Z,1);
    add(1,32'h1004,0,0,0,1,DA, 1,0,0,0,Z,1);
    add(1,32'h1004,0,0,0,0,Z,  1,0,32'h1000,1,DA,1);
    add(1,32'h1004,1,0,0,0,Z,  0,0,0,0,Z,1);
    // Backpressure: ready low four cycles; recovery during FILL does not cancel it
    add(1,32'h2005,0,0,0,0,Z,  1,0,0,0,Z,1);
    add(1,32'h2005,0,0,0,0,Z,  1,1,32'h2000,0,Z,1);
    add(1,32'h2005,0,0,0,0,Z,  1,1,32'h2000,0,Z,1);
    add(1,32'h2005,0,0,0,0,Z,  1,1,32'h2000,0,Z,1);
    add(1,32'h2005,0,0,0,0,Z,  1,1,32'h2000,0,Z,1);
    add(1,32'h2005,0,0,1,0,Z,  1,1,32'h2000,0,Z,1);
    add(1,32'h2005,0,0,1,0,Z,  1,0,0,0,Z,2);
    add(1,32'h2005,0,0,0,1,DB, 1,0,0,0,Z,2);
    add(1,32'h2005,0,1,0,0,Z,  1,0,32'h2000,1,DB,2);
    add(1,32'h2005,1,0,0,0,Z,  0,0,0,0,Z,2);
    // Flush in WAIT, owed response drained, then a fresh miss
    add(1,32'h3000,0,0,0,0,Z,  1,0,0,0,Z,2);
    add(1,32'h3000,0,0,1,0,Z,  1,1,32'h3000,0,Z,2);
    add(0,32'h0,0,0,0,0,Z,     1,0,0,0,Z,3);
    add(0,32'h0,0,1,0,0,Z,     1,0,0,0,Z,3);
    add(0,32'h0,0,0,0,0,Z,     1,0,0,0,Z,3);
    add(0,32'h0,0,0,0,0,Z,     1,0,0,0,Z,3);
    add(0,32'h0,0,0,0,0,Z,     1,0,0,0,Z,3);
    add(0,32'h0,0,0,0,1,DC,    1,0,0,0,Z,3);
    add(1,32'h4010,0,0,0,0,Z,  1,0,0,0,Z,3);
    add(1,32'h4010,0,0,0,0,Z,  1,1,32'h4010,0,Z,3);
    add(1,32'h4010,0,0,1,0,Z,  1,1,32'h4010,0,Z,3);
    add(1,32'h4010,0,0,0,1,DC, 1,0,0,0,Z,4);
    add(0,32'h0,0,0,0,0,Z,     1,0,32'h4010,1,DC,4);
    add(0,32'h0,0,0,0,0,Z,     0,0,0,0,Z,4);
    // Flush in REQ before ready: request withdrawn, count unchanged
    add(1,32'h5000,0,0,0,0,Z,  1,0,0,0,Z,4);
    add(1,32'h5000,0,1,0,0,Z,  1,1,32'h5000,0,Z,4);
    add(0,32'h0,0,0,0,0,Z,     0,0,0,0,Z,4);
    add(0,32'h0,0,0,0,0,Z,     0,0,0,0,Z,4);
    // Recovery and response together in WAIT
    add(1,32'h6000,0,0,0,0,Z,  1,0,0,0,Z,4);
    add(1,32'h6000,0,0,1,0,Z,  1,1,32'h6000,0,Z,4);
    add(0,32'h0,0,1,0,1,DA,    1,0,0,0,Z,5);
    add(0,32'h0,0,0,0,0,Z,     0,0,0,0,Z,5);
    add(0,32'h0,0,0,0,0,Z,     0,0,0,0,Z,5);
    // Miss coincident with recovery in IDLE
    add(1,32'h7000,0,1,0,0,Z,  0,0,0,0,Z,5);
    add(0,32'h0,0,0,0,0,Z,     0,0,0,0,Z,5);
    // Recovery together with ready: accepted, then drained
    add(1,32'h7008,0,0,0,0,Z,  1,0,0,0,Z,5);
    add(1,32'h7008,0,1,1,0,Z,  1,1,32'h7008,0,Z,5);
    add(0,32'h0,0,0,0,0,Z,     1,0,0,0,Z,6);
    add(0,32'h0,0,0,0,1,DB,    1,0,0,0,Z,6);
    add(0,32'h0,0,0,0,0,Z,     0,0,0,0,Z,6);
    // Stray response in IDLE
    add(0,32'h0,0,0,0,1,DA,    0,0,0,0,Z,6);
    add(0,32'h0,0,0,0,0,Z,     0,0,0,0,Z,6);

    // Reset values
    @(negedge clk); #1;
    chk("rst_req_valid", 64'(mem_req_valid), 64'h0);
    chk("rst_req_addr", 64'(mem_req_addr), 64'h0);
    chk("rst_refill_we", 64'(refill_we), 64'h0);
    chk("rst_refill_addr", 64'(refill_addr), 64'h0);
    chk("rst_refill_data", refill_data, 64'h0);
    chk("rst_miss_count", 64'(miss_count), 64'h0);
    chk("rst_stall", 64'(miss_stall), 64'h0);
    lookup_valid = 1'b1; #1;
    chk("rst_idle_miss_stall", 64'(miss_stall), 64'h1);
    lookup_valid = 1'b0;
    @(negedge clk); rst_aH = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      vidx = i;
      @(negedge clk);
      drive(vecs[i].lv, vecs[i].addr, vecs[i].hit, vecs[i].rec, vecs[i].rdy, vecs[i].rsp, vecs[i].data);
      #1;
      chk("miss_stall", 64'(miss_stall), 64'(vecs[i].e_stall));
      chk("mem_req_valid", 64'(mem_req_valid), 64'(vecs[i].e_rv));
      chk("refill_we", 64'(refill_we), 64'(vecs[i].e_we));
      chk("miss_count", 64'(miss_count), 64'(vecs[i].e_cnt));
      chk("small_count", 64'(s_miss_count), 64'(vecs[i].e_cnt));
      if (vecs[i].e_rv) chk("mem_req_addr", 64'(mem_req_addr), 64'(vecs[i].e_addr));
      if (vecs[i].e_we) begin
        chk("refill_addr", 64'(refill_addr), 64'(vecs[i].e_addr));
        chk("refill_data", refill_data, vecs[i].e_wdata);
      end
      $display("vec %0d lv=%b addr=%h rec=%b rdy=%b rsp=%b -> stall=%b rv=%b we=%b cnt=%0d",
               i, vecs[i].lv, vecs[i].addr, vecs[i].rec, vecs[i].rdy, vecs[i].rsp,
               miss_stall, mem_req_valid, refill_we, miss_count);
    end

    // Async reset in the middle of WAIT
    vidx = 1000;
    @(negedge clk); drive(1'b1, 32'h8000, 1'b0, 1'b0, 1'b0, 1'b0, Z);
    @(negedge clk); drive(1'b1, 32'h8000, 1'b0, 1'b0, 1'b1, 1'b0, Z);
    @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, Z);
    #1;
    chk("wait_stall", 64'(miss_stall), 64'h1);
    chk("wait_count", 64'(miss_count), 64'h7);
    #1 rst_aH = 1'b1;
    #1;
    chk("arst_req_valid", 64'(mem_req_valid), 64'h0);
    chk("arst_req_addr", 64'(mem_req_addr), 64'h0);
    chk("arst_refill_we", 64'(refill_we), 64'h0);
    chk("arst_refill_addr", 64'(refill_addr), 64'h0);
    chk("arst_refill_data", refill_data, 64'h0);
    chk("arst_miss_count", 64'(miss_count), 64'h0);
    chk("arst_stall", 64'(miss_stall), 64'h0);
    $display("async reset mid-WAIT: rv=%b we=%b cnt=%0d", mem_req_valid, refill_we, miss_count);
    @(negedge clk); rst_aH = 1'b0;
    @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, DA);
    #1; chk("stray_stall", 64'(miss_stall), 64'h0);
    @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, Z);
    #1;
    chk("stray_refill_we", 64'(refill_we), 64'h0);
    chk("stray_req_valid", 64'(mem_req_valid), 64'h0);
    $display("stray response after reset: we=%b rv=%b", refill_we, mem_req_valid);

    // Saturation: 20 accepted requests; the 4-bit counter must stop at 15
    vidx = 2000;
    for (int m = 0; m < 20; m++) begin
      do_miss(32'h9000 + 32'(m * 8));
      $display("sat miss %0d cnt=%0d small=%0d", m, miss_count, s_miss_count);
    end
    @(negedge clk); #1;
    chk("sat_wide_count", 64'(miss_count), 64'd20);
    chk("sat_small_count", 64'(s_miss_count), 64'd15);
    chk("sat_idle_stall", 64'(miss_stall), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_miss_ctrl.md
# icache_miss_ctrl

Sequences instruction-cache refills for the fetch unit. On a lookup miss it stalls fetch, issues a block-aligned request to DRAM, captures the response and writes it into the I-cache, then releases the stall so the PC replays and hits. It sits between the IFU lookup path, the I-cache write port and the DRAM request/response channel. It also handles branch-recovery flushes, including flushes that arrive while a request is in flight.

## Interface
Parameters:
- ADDR_WIDTH, 32, fetch address width
- ICACHE_BLOCK_SIZE, 64, block width in bits (equals DRAM response width)
- CNT_WIDTH, 16, width of the miss performance counter

Ports:
- clk  in  1  single clock
- rst_aH  in  1  reset, asynchronous, active-high
- lookup_valid  in  1  IFU presents lookup_addr to the I-cache this cycle
- lookup_addr  in  ADDR_WIDTH  current PC
- cache_hit  in  1  I-cache hit for lookup_addr
- recovery_PC_valid  in  1  backend redirect (flush of wrong-path fetch)
- miss_stall  out  1  to the fetch stall aggregator; holds PC
- mem_req_valid  out  1  DRAM request valid
- mem_req_ready  in  1  DRAM accepts request
- mem_req_addr  out  ADDR_WIDTH  block-aligned address (offset bits zero)
- mem_resp_valid  in  1  DRAM response valid (single beat, always accepted)
- mem_resp_data  in  ICACHE_BLOCK_SIZE  refill block
- refill_we  out  1  I-cache write enable
- refill_addr  out  ADDR_WIDTH  block-aligned write address
- refill_data  out  ICACHE_BLOCK_SIZE  write data
- miss_count  out  CNT_WIDTH  saturating count of accepted DRAM requests

## Operation
- OFFSET_BITS = log2(ICACHE_BLOCK_SIZE/8). The block address is lookup_addr with the low OFFSET_BITS bits cleared.
- FSM states: IDLE, REQ, WAIT, FILL, DRAIN.
- IDLE:
  - On lookup_valid & ~cache_hit & ~recovery_PC_valid: latch the block address and go to REQ.
  - If recovery_PC_valid is high with the miss, the miss is wrong-path: stay in IDLE, no request.
  - mem_resp_valid is ignored in IDLE.
- REQ:
  - mem_req_valid = 1; mem_req_addr is the latched address, stable until accepted.
  - On mem_req_ready: go to WAIT and increment miss_count, saturating at all-ones.
  - On recovery_PC_valid without ready: go to IDLE; the request is withdrawn.
  - On recovery together with ready: the request counts as accepted; go to DRAIN.
- WAIT:
  - On mem_resp_valid: latch mem_resp_data and go to FILL.
  - On recovery_PC_valid: go to DRAIN.
  - On recovery and response in the same cycle: discard the data and go to IDLE.
- DRAIN:
  - Wait for the owed response. On mem_resp_valid, discard it (refill_we stays 0) and go to IDLE.
- FILL:
  - refill_we = 1 for exactly one cycle, with the latched address and data; then go to IDLE.
  - recovery_PC_valid does not cancel the fill, because the data is architecturally correct.
- miss_stall = (state != IDLE) | (state == IDLE & lookup_valid & ~cache_hit & ~recovery_PC_valid). The IDLE term is combinational so the PC holds in the miss cycle. Recovery has priority over stall at the PC mux.
- At most one outstanding DRAM request. No new request while in DRAIN.
- Reset mid-operation: go straight to IDLE and drop any latched request. A late response arriving in IDLE is ignored.

## Timing
- Reset values: state IDLE; mem_req_valid 0; mem_req_addr 0; refill_we 0; refill_addr 0; refill_data 0; miss_count 0. miss_stall follows its combinational equation (0 unless an IDLE miss is presented).
- All outputs except miss_stall are registered or state-decoded.
- Miss detected in cycle 0 → mem_req_valid in cycle 1.
- With ready in cycle 1, WAIT begins in cycle 2.
- Response in cycle N → refill_we in cycle N+1 → IDLE and miss_stall low in cycle N+2 → replayed lookup hits in cycle N+2.
- Minimum miss penalty: 3 cycles plus DRAM latency.
- mem_req_valid never drops without a handshake, except on recovery or reset.

## Structure
- Shared package/header holds: ADDR_WIDTH, ICACHE_BLOCK_SIZE, OFFSET_BITS, and the FSM state encoding (IDLE=0, REQ=1, WAIT=2, FILL=3, DRAIN=4, 3-bit).
- One sub-module: sat_counter (parameterized width, increment enable, saturate at max, async active-high reset), used for miss_count.
- The FSM, address latch and data latch are inline.

## Test plan
- Basic miss: hit=0 on addr 0x1004, ready=1 immediately, response 0xDEADBEEF_CAFEF00D after 5 cycles → mem_req_addr=0x1000; refill_we exactly 1 cycle with that data; miss_stall low 2 cycles after the response; miss_count=1.
- Backpressure: ready low for 4 cycles → mem_req_valid and addr 0x2000 held stable throughout; single handshake; no duplicate request.
- Flush in WAIT: recovery at cycle 3, response at cycle 7 → state DRAIN; refill_we never asserts; IDLE at cycle 8; a new miss at cycle 8 issues a request at cycle 9.
- Flush in REQ before ready → mem_req_valid drops the next cycle; miss_count unchanged; no response expected.
- Simultaneous recovery and response in WAIT → IDLE; no refill.
- Miss coincident with recovery in IDLE → no request.
- Async reset asserted mid-WAIT → all registered outputs 0 immediately; a subsequent stray mem_resp_valid produces no refill_we; miss_count saturates at 0xFFFF after 65536+ misses.
